burst_read_capture: RTL and testbench

- Datapath stage directly downstream of the CellularRAM burst-mode control unit.
- While the control unit holds the device in a synchronous burst read, this block samples the 16-bit memory data bus once per clock and qualifies each sample with the device WAIT signal.
- It counts the requested number of words and pushes them into a small FIFO.
- The consumer drains the FIFO through a read-enable/valid handshake.

---
 rtl/burst_read_capture.sv | 135 +++++++++++++
 tb/tb_burst_read_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_read_capture.sv
// Burst read capture: qualifies CellularRAM burst data with WAIT,
// counts the requested words and buffers them in a small FIFO.
module burst_read_capture #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  ResetN,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [3:0]            BurstLen,
    input  logic [DATA_W-1:0]     MemData,
    input  logic                  MemWait,
    output logic                  Capturing,
    output logic                  Done,
    output logic                  Overflow,
    input  logic                  RdEn,
    output logic [DATA_W-1:0]     RdData,
    output logic                  RdValid,
    output logic                  Empty,
    output logic                  Full,
    output logic [DEPTH_LOG2:0]   Level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } state_t;

    state_t                state;
    logic [4:0]            remaining;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   level;

    logic beatValid;
    logic push;
    logic pop;

    // A beat in the abort cycle is discarded, not buffered.
    assign beatValid = (state == StCapture) && !Abort && !MemWait;
    assign pop       = RdEn && (level != '0);
    assign push      = beatValid && ((level != FULL_LVL) || pop);

    assign Level = level;
    assign Empty = (level == '0);
    assign Full  = (level == FULL_LVL);

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state     <= StIdle;
            remaining <= '0;
            Capturing <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Abort) begin
                state     <= StIdle;
                Capturing <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (Start) begin
                            remaining <= (BurstLen == 4'd0) ? 5'd16
                                                            : {1'b0, BurstLen};
                            state     <= StCapture;
                            Capturing <= 1'b1;
                        end
                    end
                    StCapture: begin
                        // Dropped words still count so the burst stays
                        // aligned with the device.
                        if (!MemWait) begin
                            remaining <= remaining - 5'd1;
                            if (remaining == 5'd1) begin
                                state     <= StDone;
                                Capturing <= 1'b0;
                                Done      <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state     <= StIdle;
                        Capturing <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wrPtr] <= MemData;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            Overflow <= 1'b0;
            RdData   <= '0;
            RdValid  <= 1'b0;
        end else begin
            RdValid <= pop;
            if (pop) begin
                RdData <= mem[rdPtr];
                rdPtr  <= rdPtr + PTR_ONE;
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (beatValid && !push) begin
                Overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_read_capture.sv
// Directed bench for burst_read_capture: burst capture, WAIT,
// overflow, full-FIFO push/pop, abort and async reset.
module tb_burst_read_capture;

    logic        CLK;
    logic        ResetN;
    logic        Start;
    logic        Abort;
    logic [3:0]  BurstLen;
    logic [15:0] MemData;
    logic        MemWait;
    logic        Capturing;
    logic        Done;
    logic        Overflow;
    logic        RdEn;
    logic [15:0] RdData;
    logic        RdValid;
    logic        Empty;
    logic        Full;
    logic [3:0]  Level;

    int checkCount;
    int errorCount;

    burst_read_capture #(
        .DATA_W    (16),
        .DEPTH_LOG2(3)
    ) dut (
        .CLK      (CLK),
        .ResetN   (ResetN),
        .Start    (Start),
        .Abort    (Abort),
        .BurstLen (BurstLen),
        .MemData  (MemData),
        .MemWait  (MemWait),
        .Capturing(Capturing),
        .Done     (Done),
        .Overflow (Overflow),
        .RdEn     (RdEn),
        .RdData   (RdData),
        .RdValid  (RdValid),
        .Empty    (Empty),
        .Full     (Full),
        .Level    (Level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startBurst(input logic [3:0] len);
        Start    = 1'b1;
        BurstLen = len;
        tick();
        Start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic w);
        MemData = d;
        MemWait = w;
        tick();
        MemWait = 1'b1;
    endtask

    task automatic popCheck(input string tag, input logic [15:0] exp);
        RdEn = 1'b1;
        tick();
        RdEn = 1'b0;
        checkVal({tag, "_valid"}, RdValid, 1);
        checkVal({tag, "_data"}, RdData, exp);
    endtask

    task automatic resetOutputs(input string tag);
        checkVal({tag, "_cap"}, Capturing, 0);
        checkVal({tag, "_done"}, Done, 0);
        checkVal({tag, "_ovf"}, Overflow, 0);
        checkVal({tag, "_rdv"}, RdValid, 0);
        checkVal({tag, "_rdd"}, RdData, 0);
        checkVal({tag, "_lvl"}, Level, 0);
        checkVal({tag, "_empty"}, Empty, 1);
        checkVal({tag, "_full"}, Full, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        ResetN   = 1'b0;
        Start    = 1'b0;
        Abort    = 1'b0;
        BurstLen = 4'd0;
        MemData  = 16'h0000;
        MemWait  = 1'b1;
        RdEn     = 1'b0;
        tick();
        tick();
        resetOutputs("rst");
        ResetN = 1'b1;
        tick();

        // 1: four back-to-back beats
        startBurst(4'd4);
        checkVal("s1_cap", Capturing, 1);
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b0);
        beat(16'h3333, 1'b0);
        checkVal("s1_done_early", Done, 0);
        beat(16'h4444, 1'b0);
        checkVal("s1_done", Done, 1);
        checkVal("s1_lvl", Level, 4);
        checkVal("s1_cap_off", Capturing, 0);
        beat(16'hDEAD, 1'b0);
        checkVal("s1_done_once", Done, 0);
        checkVal("s1_idle_ignored", Level, 4);
        popCheck("s1_p0", 16'h1111);
        popCheck("s1_p1", 16'h2222);
        popCheck("s1_p2", 16'h3333);
        popCheck("s1_p3", 16'h4444);
        checkVal("s1_empty", Empty, 1);
        RdEn = 1'b1;
        tick();
        RdEn = 1'b0;
        checkVal("s1_emptypop_v", RdValid, 0);
        checkVal("s1_emptypop_d", RdData, 16'h4444);

        // 2: WAIT stretches the burst by two cycles
        startBurst(4'd3);
        beat(16'hA0A0, 1'b0);
        beat(16'hEEEE, 1'b1);
        beat(16'hEEEF, 1'b1);
        checkVal("s2_cap_wait", Capturing, 1);
        checkVal("s2_lvl_wait", Level, 1);
        beat(16'hB0B0, 1'b0);
        checkVal("s2_done_early", Done, 0);
        beat(16'hC0C0, 1'b0);
        checkVal("s2_done", Done, 1);
        checkVal("s2_lvl", Level, 3);
        tick();
        popCheck("s2_p0", 16'hA0A0);
        popCheck("s2_p1", 16'hB0B0);
        popCheck("s2_p2", 16'hC0C0);
        checkVal("s2_empty", Empty, 1);

        // 4: push into a full FIFO while popping
        startBurst(4'd8);
        for (int i = 0; i < 8; i++) beat(16'h4000 + 16'(i), 1'b0);
        checkVal("s4_full", Full, 1);
        checkVal("s4_done", Done, 1);
        tick();
        startBurst(4'd1);
        RdEn = 1'b1;
        beat(16'h4008, 1'b0);
        RdEn = 1'b0;
        checkVal("s4_rdv", RdValid, 1);
        checkVal("s4_rdd", RdData, 16'h4000);
        checkVal("s4_lvl", Level, 8);
        checkVal("s4_ovf", Overflow, 0);
        checkVal("s4_done2", Done, 1);
        tick();
        for (int i = 1; i <= 8; i++) popCheck("s4_drain", 16'h4000 + 16'(i));
        checkVal("s4_empty", Empty, 1);

        // 3: sixteen-word burst with no drain overflows
        startBurst(4'd0);
        for (int i = 0; i < 8; i++) beat(16'h3000 + 16'(i), 1'b0);
        checkVal("s3_full", Full, 1);
        checkVal("s3_ovf_pre", Overflow, 0);
        beat(16'h3008, 1'b0);
        checkVal("s3_ovf", Overflow, 1);
        for (int i = 9; i < 15; i++) beat(16'h3000 + 16'(i), 1'b0);
        checkVal("s3_done_early", Done, 0);
        checkVal("s3_cap", Capturing, 1);
        beat(16'h300F, 1'b0);
        checkVal("s3_done", Done, 1);
        checkVal("s3_lvl", Level, 8);
        tick();
        for (int i = 0; i < 8; i++) popCheck("s3_drain", 16'h3000 + 16'(i));
        checkVal("s3_empty", Empty, 1);

        // 5: abort mid-burst, then Start+Abort together
        startBurst(4'd6);
        beat(16'h5000, 1'b0);
        beat(16'h5001, 1'b0);
        Abort = 1'b1;
        beat(16'h5002, 1'b0);
        Abort = 1'b0;
        checkVal("s5_cap", Capturing, 0);
        checkVal("s5_lvl", Level, 2);
        checkVal("s5_done", Done, 0);
        checkVal("s5_ovf_sticky", Overflow, 1);
        beat(16'h5FFF, 1'b0);
        checkVal("s5_done_after", Done, 0);
        checkVal("s5_lvl_after", Level, 2);
        Start = 1'b1;
        Abort = 1'b1;
        BurstLen = 4'd1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        checkVal("s5_abort_wins", Capturing, 0);
        startBurst(4'd1);
        beat(16'h5003, 1'b0);
        checkVal("s5_restart_done", Done, 1);
        checkVal("s5_restart_lvl", Level, 3);
        tick();

        // 6: asynchronous reset mid-capture
        startBurst(4'd4);
        beat(16'h6666, 1'b1);
        checkVal("s6_cap_pre", Capturing, 1);
        #2;
        ResetN = 1'b0;
        #1;
        resetOutputs("s6_rst");
        tick();
        ResetN = 1'b1;
        tick();
        startBurst(4'd2);
        beat(16'h6001, 1'b0);
        beat(16'h6002, 1'b0);
        checkVal("s6_done", Done, 1);
        checkVal("s6_lvl", Level, 2);
        tick();
        popCheck("s6_p0", 16'h6001);
        popCheck("s6_p1", 16'h6002);
        checkVal("s6_empty", Empty, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
